// File: rtl/layer_ctrl_rf_pkg.sv
// layer_ctrl_rf_pkg: MBus width constants, controller state encoding, default function IDs
// and the packed register-array slice macro shared by layer_ctrl_rf and lc_rx_buffer.
`define LC_SLICE(vec, i, w) vec[(i)*(w) +: (w)]

package layer_ctrl_rf_pkg;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int FUNC_WIDTH = 4;
    localparam logic [FUNC_WIDTH-1:0] FUNC_RF_WR_DEF = 4'h2;
    localparam logic [FUNC_WIDTH-1:0] FUNC_RF_RD_DEF = 4'h3;
    typedef enum logic [2:0] {ST_IDLE, ST_RECV, ST_EXEC, ST_TX, ST_TX_WAIT} lc_state_e;
endpackage

// File: rtl/lc_rx_buffer.sv
// lc_rx_buffer: receive word store with a saturating word count and an overflow flag.
// clr and wr may coincide; the write then lands at index 0 of a freshly cleared buffer.
module lc_rx_buffer
    import layer_ctrl_rf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW = $clog2(DEPTH + 1),
    parameter int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [IW-1:0]         rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [CW-1:0]         count,
    output logic                  ovf
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0] count_q, count_d, base;
    logic ovf_q, ovf_d, room;

    always_comb begin
        base = clr ? '0 : count_q;
        room = base < CW'(DEPTH);
        count_d = (wr && room) ? base + 1'b1 : base;
        ovf_d = (!clr && ovf_q) || (wr && !room);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            ovf_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            count_q <= count_d;
            ovf_q <= ovf_d;
            if (wr && room) mem_q[base[IW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];
    assign count = count_q;
    assign ovf = ovf_q;
endmodule

// File: rtl/layer_ctrl_rf.sv
// layer_ctrl_rf: MBus layer controller executing register-file writes from buffered messages.
// Define LC_RF_READ_EN to add register reads answered with an MBus reply message.
module layer_ctrl_rf
    import layer_ctrl_rf_pkg::*;
#(
    parameter int RF_NUM = 16,
    parameter int RF_DW = 24,
    parameter int BUF_DEPTH = 4,
    parameter logic [FUNC_WIDTH-1:0] FUNC_RF_WR = FUNC_RF_WR_DEF,
    parameter logic [FUNC_WIDTH-1:0] FUNC_RF_RD = FUNC_RF_RD_DEF
) (
    input  logic                    CLK,
    input  logic                    RESETn,
    input  logic                    RELEASE_RST_FROM_MBUS,
    input  logic [ADDR_WIDTH-1:0]   RX_ADDR,
    input  logic [DATA_WIDTH-1:0]   RX_DATA,
    input  logic                    RX_PEND,
    input  logic                    RX_REQ,
    output logic                    RX_ACK,
    input  logic                    RX_BROADCAST,
    input  logic                    RX_FAIL,
    output logic [ADDR_WIDTH-1:0]   TX_ADDR,
    output logic [DATA_WIDTH-1:0]   TX_DATA,
    output logic                    TX_PEND,
    output logic                    TX_REQ,
    input  logic                    TX_ACK,
    output logic                    PRIORITY,
    input  logic                    TX_SUCC,
    input  logic                    TX_FAIL,
    output logic                    TX_RESP_ACK,
    input  logic [RF_NUM*RF_DW-1:0] RF_IN,
    output logic [RF_NUM*RF_DW-1:0] RF_OUT,
    output logic [RF_NUM-1:0]       RF_LOAD
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int IW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic rst_n;
    assign rst_n = RESETn & ~RELEASE_RST_FROM_MBUS;

    lc_state_e state_q, state_d;
    logic [FUNC_WIDTH-1:0] func_q, func_d;
    logic bcast_q, bcast_d, rx_ack_q, rx_ack_d;
    logic [CW-1:0] exec_q, exec_d, buf_cnt;
    logic [RF_NUM*RF_DW-1:0] rf_out_q, rf_out_d;
    logic [RF_NUM-1:0] rf_load_q, rf_load_d;
    logic [DATA_WIDTH-1:0] buf_rd;
    logic buf_clr, buf_wr, buf_ovf, rx_new, discard;

    function automatic logic known(input logic [FUNC_WIDTH-1:0] f);
`ifdef LC_RF_READ_EN
        return f == FUNC_RF_WR || f == FUNC_RF_RD;
`else
        return f == FUNC_RF_WR;
`endif
    endfunction

    lc_rx_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk(CLK), .rst_n(rst_n), .clr(buf_clr), .wr(buf_wr), .wr_data(RX_DATA),
        .rd_idx(exec_q[IW-1:0]), .rd_data(buf_rd), .count(buf_cnt), .ovf(buf_ovf)
    );

`ifdef LC_RF_READ_EN
    logic [7:0] rd_idx_q, rd_idx_d;
    logic [8:0] rd_left_q, rd_left_d;
    logic [ADDR_WIDTH-1:0] tx_addr_q, tx_addr_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic tx_pend_q, tx_pend_d, tx_req_q, tx_req_d, tx_resp_q, tx_resp_d;
    logic [23:0] rd_val;

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < RF_NUM; i++)
            if (rd_idx_q == 8'(i)) rd_val = 24'(`LC_SLICE(RF_IN, i, RF_DW));
    end
`endif

    always_comb begin
        state_d = state_q;
        func_d = func_q;
        bcast_d = bcast_q;
        exec_d = exec_q;
        rf_out_d = rf_out_q;
        rf_load_d = '0;
        rx_ack_d = RX_REQ | RX_FAIL;
        rx_new = RX_REQ && !rx_ack_q;
        buf_clr = 1'b0;
        buf_wr = 1'b0;
        discard = 1'b0;
`ifdef LC_RF_READ_EN
        rd_idx_d = rd_idx_q;
        rd_left_d = rd_left_q;
        tx_addr_d = tx_addr_q;
        tx_data_d = tx_data_q;
        tx_pend_d = tx_pend_q;
        tx_req_d = tx_req_q;
        tx_resp_d = tx_resp_q;
`endif
        if (RX_FAIL) begin
            state_d = ST_IDLE;
            buf_clr = 1'b1;
`ifdef LC_RF_READ_EN
            tx_req_d = 1'b0;
            tx_resp_d = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: if (rx_new) begin
                    func_d = RX_ADDR[FUNC_WIDTH-1:0];
                    bcast_d = RX_BROADCAST;
                    buf_clr = 1'b1;
                    buf_wr = 1'b1;
                    exec_d = '0;
                    state_d = RX_PEND ? ST_RECV : (known(func_d) && !bcast_d) ? ST_EXEC : ST_IDLE;
                end
                ST_RECV: if (rx_new) begin
                    buf_wr = 1'b1;
                    bcast_d = bcast_q | RX_BROADCAST;
                    discard = buf_ovf || buf_cnt == CW'(BUF_DEPTH) || bcast_d || !known(func_q);
                    if (!RX_PEND) state_d = discard ? ST_IDLE : ST_EXEC;
                end
                ST_EXEC: begin
`ifdef LC_RF_READ_EN
                    if (func_q == FUNC_RF_RD) begin
                        rd_idx_d = buf_rd[31:24];
                        rd_left_d = {1'b0, buf_rd[23:16]} + 9'd1;
                        tx_addr_d = {24'h0, buf_rd[15:8]};
                        state_d = ST_TX;
                    end else
`endif
                    begin
                        // Out-of-range indices match no register but still take their cycle.
                        for (int i = 0; i < RF_NUM; i++)
                            if (buf_rd[31:24] == 8'(i)) begin
                                `LC_SLICE(rf_out_d, i, RF_DW) = buf_rd[RF_DW-1:0];
                                rf_load_d[i] = 1'b1;
                            end
                        exec_d = exec_q + 1'b1;
                        if (exec_d == buf_cnt) state_d = ST_IDLE;
                    end
                end
`ifdef LC_RF_READ_EN
                ST_TX:
                    if (tx_req_q) begin
                        if (TX_ACK) begin
                            tx_req_d = 1'b0;
                            rd_idx_d = rd_idx_q + 8'd1;
                            rd_left_d = rd_left_q - 9'd1;
                            if (rd_left_q == 9'd1) state_d = ST_TX_WAIT;
                        end
                    end else if (!TX_ACK) begin
                        tx_req_d = 1'b1;
                        tx_data_d = {rd_idx_q, rd_val};
                        tx_pend_d = rd_left_q != 9'd1;
                    end
                ST_TX_WAIT:
                    if (TX_SUCC || TX_FAIL) tx_resp_d = 1'b1;
                    else if (tx_resp_q) begin
                        tx_resp_d = 1'b0;
                        state_d = ST_IDLE;
                    end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            func_q <= '0;
            bcast_q <= 1'b0;
            rx_ack_q <= 1'b0;
            exec_q <= '0;
            rf_out_q <= '0;
            rf_load_q <= '0;
`ifdef LC_RF_READ_EN
            rd_idx_q <= '0;
            rd_left_q <= '0;
            tx_addr_q <= '0;
            tx_data_q <= '0;
            tx_pend_q <= 1'b0;
            tx_req_q <= 1'b0;
            tx_resp_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            func_q <= func_d;
            bcast_q <= bcast_d;
            rx_ack_q <= rx_ack_d;
            exec_q <= exec_d;
            rf_out_q <= rf_out_d;
            rf_load_q <= rf_load_d;
`ifdef LC_RF_READ_EN
            rd_idx_q <= rd_idx_d;
            rd_left_q <= rd_left_d;
            tx_addr_q <= tx_addr_d;
            tx_data_q <= tx_data_d;
            tx_pend_q <= tx_pend_d;
            tx_req_q <= tx_req_d;
            tx_resp_q <= tx_resp_d;
`endif
        end
    end

    assign RX_ACK = rx_ack_q;
    assign RF_OUT = rf_out_q;
    assign RF_LOAD = rf_load_q;
    assign PRIORITY = 1'b0;
`ifdef LC_RF_READ_EN
    assign TX_ADDR = tx_addr_q;
    assign TX_DATA = tx_data_q;
    assign TX_PEND = tx_pend_q;
    assign TX_REQ = tx_req_q;
    assign TX_RESP_ACK = tx_resp_q;
    logic unused_sink;
    assign unused_sink = ^buf_rd;
`else
    assign TX_ADDR = '0;
    assign TX_DATA = '0;
    assign TX_PEND = 1'b0;
    assign TX_REQ = 1'b0;
    assign TX_RESP_ACK = 1'b0;
    logic unused_sink;
    assign unused_sink = ^{buf_rd, TX_ACK, TX_SUCC, TX_FAIL, RF_IN, FUNC_RF_RD};
`endif
endmodule

// File: tb/tb_layer_ctrl_rf.sv
// tb_layer_ctrl_rf: directed bench for layer_ctrl_rf; expected RF writes and reply words are
// queued as stimulus is issued and popped by a monitor whenever the DUT strobes an output.
`timescale 1ns/1ps
module tb_layer_ctrl_rf;
    localparam int RF_NUM = 16;
    localparam int RF_DW = 24;

    logic CLK = 1'b0, RESETn = 1'b0, RELEASE_RST_FROM_MBUS = 1'b0;
    logic [31:0] RX_ADDR = '0, RX_DATA = '0;
    logic RX_PEND = 1'b0, RX_REQ = 1'b0, RX_BROADCAST = 1'b0, RX_FAIL = 1'b0;
    logic RX_ACK;
    logic [31:0] TX_ADDR, TX_DATA;
    logic TX_PEND, TX_REQ, PRIORITY, TX_RESP_ACK;
    logic TX_ACK = 1'b0, TX_SUCC = 1'b0, TX_FAIL = 1'b0;
    logic [RF_NUM*RF_DW-1:0] RF_IN = '0;
    logic [RF_NUM*RF_DW-1:0] RF_OUT;
    logic [RF_NUM-1:0] RF_LOAD;

    int n_assert = 0, n_fail = 0;

    typedef struct { logic [15:0] load; int r; logic [23:0] data; } wr_t;
    typedef struct { logic [31:0] data; logic pend; } tx_t;
    wr_t wr_q[$];
    tx_t tx_q[$];
    wr_t we;
    tx_t te;
    logic tx_req_prev = 1'b0;

    always #5 CLK = ~CLK;

    layer_ctrl_rf dut (
        .CLK(CLK), .RESETn(RESETn), .RELEASE_RST_FROM_MBUS(RELEASE_RST_FROM_MBUS),
        .RX_ADDR(RX_ADDR), .RX_DATA(RX_DATA), .RX_PEND(RX_PEND), .RX_REQ(RX_REQ),
        .RX_ACK(RX_ACK), .RX_BROADCAST(RX_BROADCAST), .RX_FAIL(RX_FAIL),
        .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA), .TX_PEND(TX_PEND), .TX_REQ(TX_REQ),
        .TX_ACK(TX_ACK), .PRIORITY(PRIORITY), .TX_SUCC(TX_SUCC), .TX_FAIL(TX_FAIL),
        .TX_RESP_ACK(TX_RESP_ACK), .RF_IN(RF_IN), .RF_OUT(RF_OUT), .RF_LOAD(RF_LOAD)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every RF_LOAD strobe and every new reply word must match the head of its queue.
    always @(negedge CLK) begin
        if (RF_LOAD !== '0) begin
            if (wr_q.size() == 0) chk("rf_load_unexpected", 64'(RF_LOAD), 64'(0));
            else begin
                we = wr_q.pop_front();
                chk("rf_load", 64'(RF_LOAD), 64'(we.load));
                chk("rf_out", 64'(RF_OUT[we.r*RF_DW +: RF_DW]), 64'(we.data));
            end
        end
        if (TX_REQ === 1'b1 && !tx_req_prev) begin
            if (tx_q.size() == 0) chk("tx_req_unexpected", 64'(TX_DATA), 64'(0));
            else begin
                te = tx_q.pop_front();
                chk("tx_word", {31'h0, TX_PEND, TX_DATA}, {31'h0, te.pend, te.data});
            end
        end
        tx_req_prev = TX_REQ;
    end

    task automatic wait_rx_ack(input logic lvl);
        int k = 0;
        while (RX_ACK !== lvl && k < 20) begin @(negedge CLK); k++; end
        chk("rx_ack_handshake", 64'(RX_ACK), 64'(lvl));
    endtask

    task automatic wait_tx_req(input logic lvl);
        int k = 0;
        while (TX_REQ !== lvl && k < 40) begin @(negedge CLK); k++; end
        chk("tx_req_handshake", 64'(TX_REQ), 64'(lvl));
    endtask

    task automatic wait_resp(input logic lvl);
        int k = 0;
        while (TX_RESP_ACK !== lvl && k < 20) begin @(negedge CLK); k++; end
        chk("tx_resp_ack", 64'(TX_RESP_ACK), 64'(lvl));
    endtask

    task automatic send_word(input logic [31:0] a, input logic [31:0] d, input logic p, input logic b);
        @(negedge CLK);
        RX_ADDR = a; RX_DATA = d; RX_PEND = p; RX_BROADCAST = b; RX_REQ = 1'b1;
        @(negedge CLK);
        wait_rx_ack(1'b1);
        RX_REQ = 1'b0;
        @(negedge CLK);
        wait_rx_ack(1'b0);
        RX_BROADCAST = 1'b0;
    endtask

    task automatic send_fail();
        @(negedge CLK);
        RX_FAIL = 1'b1;
        @(negedge CLK);
        wait_rx_ack(1'b1);
        RX_FAIL = 1'b0;
        @(negedge CLK);
        wait_rx_ack(1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ctrl"}, {43'h0, RX_ACK, TX_REQ, TX_PEND, TX_RESP_ACK, PRIORITY, RF_LOAD}, 64'h0);
        chk({name, "_tx"}, {TX_ADDR, TX_DATA}, 64'h0);
        chk({name, "_rf_out"}, 64'(RF_OUT !== '0), 64'h0);
    endtask

    initial begin
        idle(3);
        chk_all_zero("reset");
        RESETn = 1'b1;
        idle(2);

        // Single-word write to register 5.
        wr_q.push_back('{16'h0020, 5, 24'h00ABCD});
        send_word(32'h2, 32'h0500ABCD, 1'b0, 1'b0);
        idle(5);
        chk("t1_drain", 64'(wr_q.size()), 64'(0));
        chk("t1_rf_out5", 64'(RF_OUT[5*RF_DW +: RF_DW]), 64'h00ABCD);

        // Three words to regs 1, 20, 2; reg 20 is out of range.
        wr_q.push_back('{16'h0002, 1, 24'h000111});
        wr_q.push_back('{16'h0004, 2, 24'h000333});
        send_word(32'h2, 32'h01000111, 1'b1, 1'b0);
        send_word(32'h2, 32'h14000222, 1'b1, 1'b0);
        send_word(32'h2, 32'h02000333, 1'b0, 1'b0);
        idle(6);
        chk("t2_drain", 64'(wr_q.size()), 64'(0));
        chk("t2_rf_out5_hold", 64'(RF_OUT[5*RF_DW +: RF_DW]), 64'h00ABCD);

        // Five words overflow a four-word buffer: all acked, nothing written.
        for (int i = 0; i < 5; i++) send_word(32'h2, 32'h06000600 + 32'(i), (i != 4), 1'b0);
        idle(6);
        chk("t3_rf_out6", 64'(RF_OUT[6*RF_DW +: RF_DW]), 64'h0);

        // Reception aborted after word 2, then a normal message.
        send_word(32'h2, 32'h07000777, 1'b1, 1'b0);
        send_word(32'h2, 32'h08000888, 1'b1, 1'b0);
        send_fail();
        idle(4);
        chk("t4_rf_out7", 64'(RF_OUT[7*RF_DW +: RF_DW]), 64'h0);
        chk("t4_rf_out8", 64'(RF_OUT[8*RF_DW +: RF_DW]), 64'h0);
        wr_q.push_back('{16'h0080, 7, 24'h000999});
        send_word(32'h2, 32'h07000999, 1'b0, 1'b0);
        idle(5);
        chk("t4_drain", 64'(wr_q.size()), 64'(0));

        // Broadcast write and unknown function are discarded.
        send_word(32'h2, 32'h09000123, 1'b0, 1'b1);
        send_word(32'h5, 32'h0A000456, 1'b0, 1'b0);
        idle(5);
        chk("t5_bcast_rf_out9", 64'(RF_OUT[9*RF_DW +: RF_DW]), 64'h0);
        chk("t5_unknown_rf_out10", 64'(RF_OUT[10*RF_DW +: RF_DW]), 64'h0);

        RF_IN[3*RF_DW +: RF_DW] = 24'h111111;
        RF_IN[4*RF_DW +: RF_DW] = 24'h222222;
        RF_IN[5*RF_DW +: RF_DW] = 24'h333333;
`ifdef LC_RF_READ_EN
        // Read three registers starting at 3, reply to address 0x77.
        tx_q.push_back('{32'h03111111, 1'b1});
        tx_q.push_back('{32'h04222222, 1'b1});
        tx_q.push_back('{32'h05333333, 1'b0});
        send_word(32'h3, 32'h03027700, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            wait_tx_req(1'b1);
            TX_ACK = 1'b1;
            @(negedge CLK);
            wait_tx_req(1'b0);
            TX_ACK = 1'b0;
        end
        chk("t6_tx_addr", 64'(TX_ADDR), 64'h77);
        idle(2);
        TX_SUCC = 1'b1;
        @(negedge CLK);
        wait_resp(1'b1);
        TX_SUCC = 1'b0;
        @(negedge CLK);
        wait_resp(1'b0);
        chk("t6_tx_drain", 64'(tx_q.size()), 64'(0));

        // Reset asserted while the reply is in flight.
        tx_q.push_back('{32'h03111111, 1'b1});
        send_word(32'h3, 32'h03017700, 1'b0, 1'b0);
        wait_tx_req(1'b1);
        RESETn = 1'b0;
        #1;
        chk_all_zero("midtx_reset");
`else
        // Read function is not built in: message discarded, no reply.
        send_word(32'h3, 32'h03027700, 1'b0, 1'b0);
        idle(6);
        chk("t6_no_tx_req", 64'(TX_REQ), 64'h0);
        chk("t6_no_write_rf_out3", 64'(RF_OUT[3*RF_DW +: RF_DW]), 64'h0);

        // Reset asserted mid-reception.
        send_word(32'h2, 32'h0B000BBB, 1'b1, 1'b0);
        @(negedge CLK);
        RX_REQ = 1'b1;
        @(negedge CLK);
        wait_rx_ack(1'b1);
        RESETn = 1'b0;
        #1;
        chk_all_zero("midrx_reset");
        RX_REQ = 1'b0;
`endif
        idle(2);
        RESETn = 1'b1;
        idle(2);

        // RELEASE_RST_FROM_MBUS holds the block in reset.
        wr_q.push_back('{16'h0020, 5, 24'h000555});
        send_word(32'h2, 32'h05000555, 1'b0, 1'b0);
        idle(5);
        RELEASE_RST_FROM_MBUS = 1'b1;
        #1;
        chk_all_zero("release_rst");
        idle(2);
        RELEASE_RST_FROM_MBUS = 1'b0;
        idle(2);

        wr_q.push_back('{16'h0800, 11, 24'h000BBB});
        send_word(32'h2, 32'h0B000BBB, 1'b0, 1'b0);
        idle(6);
        chk("final_wr_drain", 64'(wr_q.size()), 64'(0));
        chk("final_tx_drain", 64'(tx_q.size()), 64'(0));
        chk("final_rf_out11", 64'(RF_OUT[11*RF_DW +: RF_DW]), 64'h000BBB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
